// File: rtl/p_cdc_evt_sched.sv
// rtl/p_cdc_evt_sched.sv - round-robin event scheduler with a 4-phase req/ack handshake to an async domain
// Optional build macro P_CDC_EVT_SCHED_CNT_EN: 3-bit pending counters instead of 1-bit sticky flags.
module p_cdc_evt_sched #(
  parameter int NSRC = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            clr_,
  input  logic [NSRC-1:0] evt_in,
  input  logic            ack_async,
  output logic            req,
  output logic [IDW-1:0]  req_id,
  output logic            done,
  output logic [NSRC-1:0] drop,
  output logic            busy
);

`ifdef P_CDC_EVT_SCHED_CNT_EN
  localparam int CW = 3;
`else
  localparam int CW = 1;
`endif
  localparam logic [CW-1:0] FULL = '1;

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t            state_q, state_d;
  logic              ack_m_q, ack_s_q;
  logic [CW-1:0]     pend_q [NSRC];
  logic [CW-1:0]     pend_d [NSRC];
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    req_id_q, req_id_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic [NSRC-1:0]   drop_q, drop_d;
  logic [NSRC-1:0]   pend_nz, dec;
  logic [2*NSRC-1:0] dbl;
  logic [NSRC-1:0]   rot;
  logic [IDW-1:0]    win;
  logic              any_pend;

  always_comb begin
    for (int i = 0; i < NSRC; i++) pend_nz[i] = (pend_q[i] != '0);
    any_pend = |pend_nz;
  end

  // Rotate the pending map so the pointer lands at bit 0; the lowest set bit is the winner.
  always_comb begin
    dbl = {pend_nz, pend_nz} >> ptr_q;
    rot = dbl[NSRC-1:0];
    win = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (rot[k]) win = IDW'((int'(ptr_q) + k) % NSRC);
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    req_id_d = req_id_q;
    ptr_d    = ptr_q;
    done_d   = 1'b0;
    dec      = '0;
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          dec      = NSRC'(1) << win;
          req_id_d = win;
          req_d    = 1'b1;
          ptr_d    = (int'(win) == NSRC - 1) ? '0 : win + 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (ack_s_q) begin
          req_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        if (!ack_s_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // A same-cycle event on the granted source re-fills the slot being released.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      pend_d[i] = pend_q[i];
      drop_d[i] = 1'b0;
      if (dec[i]) pend_d[i] = pend_d[i] - CW'(1);
      if (evt_in[i]) begin
        if (pend_q[i] == FULL && !dec[i]) drop_d[i] = 1'b1;
        else                              pend_d[i] = pend_d[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      ack_m_q  <= 1'b0;
      ack_s_q  <= 1'b0;
      state_q  <= IDLE;
      req_q    <= 1'b0;
      req_id_q <= '0;
      ptr_q    <= '0;
      done_q   <= 1'b0;
      drop_q   <= '0;
      for (int i = 0; i < NSRC; i++) pend_q[i] <= '0;
    end else begin
      ack_m_q  <= ack_async;
      ack_s_q  <= ack_m_q;
      state_q  <= state_d;
      req_q    <= req_d;
      req_id_q <= req_id_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      for (int i = 0; i < NSRC; i++) pend_q[i] <= pend_d[i];
    end
  end

  assign req    = req_q;
  assign req_id = req_id_q;
  assign done   = done_q;
  assign drop   = drop_q;
  assign busy   = (state_q != IDLE) || any_pend;

endmodule

// File: tb/tb_p_cdc_evt_sched.sv
// tb/tb_p_cdc_evt_sched.sv - randomized bench for p_cdc_evt_sched with a pending-count/round-robin reference model
module tb_p_cdc_evt_sched;
  localparam int NSRC = 4;
  localparam int IDW  = 2;
`ifdef P_CDC_EVT_SCHED_CNT_EN
  localparam int FULL = 7;
`else
  localparam int FULL = 1;
`endif

  logic            clk = 1'b0;
  logic            clr_ = 1'b0;
  logic [NSRC-1:0] evt_in = '0;
  logic            ack_async = 1'b0;
  logic            req;
  logic [IDW-1:0]  req_id;
  logic            done;
  logic [NSRC-1:0] drop;
  logic            busy;

  p_cdc_evt_sched #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clk(clk), .clr_(clr_), .evt_in(evt_in), .ack_async(ack_async),
    .req(req), .req_id(req_id), .done(done), .drop(drop), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // remote side: acks ack_dly cycles after seeing req, releases rel_dly cycles after req drops
  int ack_dly = 2, rel_dly = 2, rcnt = 0;
  bit spur = 0, rnd_dly = 0;
  initial forever begin
    @(posedge clk); #1;
    if (!clr_) begin
      ack_async = 1'b0; rcnt = 0;
    end else if (spur) begin
      rcnt = 0;
    end else if (req && !ack_async) begin
      rcnt++;
      if (rcnt >= ack_dly) begin ack_async = 1'b1; rcnt = 0; end
    end else if (!req && ack_async) begin
      rcnt++;
      if (rcnt >= rel_dly) begin
        ack_async = 1'b0; rcnt = 0;
        if (rnd_dly) begin ack_dly = $urandom_range(0, 4); rel_dly = $urandom_range(0, 4); end
      end
    end else begin
      rcnt = 0;
    end
  end

  // reference model: pending counts per source, round-robin pointer, handshake-active flag
  int              m_pend [NSRC];
  int              m_ptr = 0;
  bit              m_active = 0;
  bit              prev_req = 0;
  logic [NSRC-1:0] evt_prev = '0;
  logic [IDW-1:0]  last_id = '0;
  int              grants[$];
  int              n_done = 0;
  int              n_drop [NSRC];
  int              n_evt = 0;

  always @(negedge clk) begin : mon
    int w, idx;
    bit granted, exp_g, dec_s, acc;
    logic [NSRC-1:0] exp_drop;
    logic exp_busy;
    cyc++;
    if (!clr_) begin
      vectors++;
      if ({req, req_id, done, drop, busy} !== '0)
        begin errors++; $display("FAIL reset_outputs cyc=%0d got=%b exp=0", cyc, {req, req_id, done, drop, busy}); end
      for (int s = 0; s < NSRC; s++) m_pend[s] = 0;
      m_ptr = 0; m_active = 0; prev_req = 0; evt_prev = '0;
    end else begin
      w = -1;
      for (int k = 0; k < NSRC; k++) begin
        idx = (m_ptr + k) % NSRC;
        if (w < 0 && m_pend[idx] > 0) w = idx;
      end
      granted = req && !prev_req;
      exp_g   = !m_active && (w >= 0);
      vectors++;
      if (granted !== exp_g)
        begin errors++; $display("FAIL grant_timing cyc=%0d got=%0b exp=%0b", cyc, granted, exp_g); end
      if (granted && w >= 0) begin
        vectors++;
        if (req_id !== IDW'(w))
          begin errors++; $display("FAIL grant_id cyc=%0d got=%0d exp=%0d", cyc, req_id, w); end
        m_ptr = (w + 1) % NSRC;
        m_active = 1;
        grants.push_back(int'(req_id));
        last_id = req_id;
      end
      for (int s = 0; s < NSRC; s++) begin
        dec_s = granted && (w == s);
        acc   = evt_prev[s] && !(m_pend[s] == FULL && !dec_s);
        exp_drop[s] = evt_prev[s] && !acc;
        m_pend[s] = m_pend[s] - (dec_s ? 1 : 0) + (acc ? 1 : 0);
        if (drop[s]) n_drop[s]++;
      end
      vectors++;
      if (drop !== exp_drop)
        begin errors++; $display("FAIL drop cyc=%0d got=%b exp=%b", cyc, drop, exp_drop); end
      if (done) begin
        vectors++;
        if (!(m_active && !req))
          begin errors++; $display("FAIL done_pulse cyc=%0d got=1 exp=0 active=%0b req=%0b", cyc, m_active, req); end
        m_active = 0;
        n_done++;
      end
      if (m_active && !granted) begin
        vectors++;
        if (req_id !== last_id)
          begin errors++; $display("FAIL req_id_stable cyc=%0d got=%0d exp=%0d", cyc, req_id, last_id); end
      end
      exp_busy = m_active;
      for (int s = 0; s < NSRC; s++) if (m_pend[s] > 0) exp_busy = 1'b1;
      vectors++;
      if (busy !== exp_busy)
        begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      evt_prev = evt_in;
      prev_req = req;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic [NSRC-1:0] v);
    evt_in = v;
    for (int s = 0; s < NSRC; s++) if (v[s]) n_evt++;
    tick(1);
    evt_in = '0;
  endtask

  task automatic clear_log();
    grants.delete();
    n_done = 0; n_evt = 0;
    for (int s = 0; s < NSRC; s++) n_drop[s] = 0;
  endtask

  task automatic do_reset();
    clr_ = 1'b0; evt_in = '0;
    tick(3);
    clear_log();
    clr_ = 1'b1;
  endtask

  task automatic wait_req(input string tag);
    int i;
    for (i = 0; i < 100 && !req; i++) tick(1);
    vectors++;
    if (!req) begin errors++; $display("FAIL %s_req_timeout got=0 exp=1", tag); end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && !ack_async) break;
    end
    vectors++;
    if (busy) begin errors++; $display("FAIL %s_idle_timeout busy=%b exp=0", tag, busy); end
    tick(1);
  endtask

  task automatic test_reset();
    clr_ = 1'b0;
    tick(2);
    vectors++;
    if ({req, req_id, done, drop, busy} !== '0)
      begin errors++; $display("FAIL test_reset got=%b exp=0", {req, req_id, done, drop, busy}); end
  endtask

  task automatic test_single();
    do_reset();
    ack_dly = 2; rel_dly = 2;
    pulse(4'b0001);
    vectors++;
    if (req !== 1'b0) begin errors++; $display("FAIL single_cyc1_req got=%b exp=0", req); end
    tick(1);
    vectors++;
    if (req !== 1'b1 || req_id !== 2'd0)
      begin errors++; $display("FAIL single_cyc2 got req=%b id=%0d exp req=1 id=0", req, req_id); end
    for (int i = 0; i < 50 && n_done == 0; i++) @(negedge clk);
    @(negedge clk);
    vectors++;
    if (n_done !== 1 || busy !== 1'b0)
      begin errors++; $display("FAIL single_done got done=%0d busy=%b exp done=1 busy=0", n_done, busy); end
    tick(1);
  endtask

  task automatic test_all_four();
    do_reset();
    pulse(4'b1111);
    wait_idle("all4", 300);
    vectors++;
    if (grants.size() !== 4 || n_done !== 4)
      begin errors++; $display("FAIL all4_count got=%0d/%0d exp=4/4", grants.size(), n_done); end
    else
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (grants[i] !== i) begin errors++; $display("FAIL all4_order[%0d] got=%0d exp=%0d", i, grants[i], i); end
      end
    vectors++;
    if (n_drop[0] + n_drop[1] + n_drop[2] + n_drop[3] !== 0)
      begin errors++; $display("FAIL all4_drop got=%0d exp=0", n_drop[0] + n_drop[1] + n_drop[2] + n_drop[3]); end
  endtask

  task automatic test_rr();
    int exp_q[3] = '{2, 1, 2};
    do_reset();
    ack_dly = 6;
    pulse(4'b0100);
    wait_req("rr");
    pulse(4'b0110);
    wait_idle("rr", 300);
    ack_dly = 2;
    vectors++;
    if (grants.size() !== 3) begin errors++; $display("FAIL rr_count got=%0d exp=3", grants.size()); end
    else
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (grants[i] !== exp_q[i]) begin errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, grants[i], exp_q[i]); end
      end
  endtask

  task automatic test_saturation();
    int exp_drops = (FULL == 1) ? 2 : 0;
    int exp_gr    = (FULL == 1) ? 2 : 4;
    do_reset();
    ack_dly = 10;
    pulse(4'b0001);
    wait_req("sat");
    repeat (3) begin pulse(4'b0001); tick(1); end
    wait_idle("sat", 400);
    ack_dly = 2;
    vectors++;
    if (n_drop[0] !== exp_drops) begin errors++; $display("FAIL sat_drops got=%0d exp=%0d", n_drop[0], exp_drops); end
    vectors++;
    if (grants.size() !== exp_gr) begin errors++; $display("FAIL sat_grants got=%0d exp=%0d", grants.size(), exp_gr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    ack_dly = 4;
    pulse(4'b0010);
    wait_req("arst");
    pulse(4'b1000);
    @(negedge clk); #2;
    clr_ = 1'b0;
    #1;
    vectors++;
    if (req !== 1'b0) begin errors++; $display("FAIL arst_req got=%b exp=0", req); end
    tick(3);
    clr_ = 1'b1;
    clear_log();
    ack_dly = 2;
    tick(5);
    vectors++;
    if (busy !== 1'b0 || req !== 1'b0)
      begin errors++; $display("FAIL arst_quiet got busy=%b req=%b exp 0 0", busy, req); end
    pulse(4'b0011);
    wait_idle("arst", 300);
    vectors++;
    if (grants.size() !== 2 || grants[0] !== 0)
      begin errors++; $display("FAIL arst_ptr got n=%0d first=%0d exp n=2 first=0", grants.size(), grants.size() > 0 ? grants[0] : -1); end
  endtask

  task automatic test_spurious_ack();
    do_reset();
    tick(2);
    spur = 1; ack_async = 1'b1;
    tick(5);
    ack_async = 1'b0;
    tick(5);
    spur = 0;
    vectors++;
    if (req !== 1'b0 || n_done !== 0 || grants.size() !== 0)
      begin errors++; $display("FAIL spur_ack got req=%b done=%0d gr=%0d exp 0 0 0", req, n_done, grants.size()); end
    pulse(4'b0100);
    wait_idle("spur", 300);
    vectors++;
    if (grants.size() !== 1 || grants[0] !== 2)
      begin errors++; $display("FAIL spur_after got n=%0d exp n=1 id=2", grants.size()); end
  endtask

  task automatic test_random();
    logic [NSRC-1:0] v;
    int nd;
    do_reset();
    rnd_dly = 1;
    for (int c = 0; c < 3000; c++) begin
      v = '0;
      for (int s = 0; s < NSRC; s++) if ($urandom_range(0, 7) == 0) v[s] = 1'b1;
      pulse(v);
    end
    wait_idle("rand", 3000);
    rnd_dly = 0; ack_dly = 2; rel_dly = 2;
    nd = n_drop[0] + n_drop[1] + n_drop[2] + n_drop[3];
    vectors++;
    if (n_done !== grants.size())
      begin errors++; $display("FAIL rand_done got=%0d exp=%0d", n_done, grants.size()); end
    vectors++;
    if (n_evt !== grants.size() + nd)
      begin errors++; $display("FAIL rand_conserve got=%0d exp=%0d", grants.size() + nd, n_evt); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < NSRC; s++) begin m_pend[s] = 0; n_drop[s] = 0; end
    test_reset();
    test_single();
    test_all_four();
    test_rr();
    test_saturation();
    test_async_reset();
    test_spurious_ack();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
